fire_sequencer: RTL and testbench

//  Parametrised multi-channel successor to the single-channel arm/fire path. Debounces the arm
//  and fire buttons and gates the charger. Fires NCH igniter channels in ascending order, each
//  for a fixed pulse width with a fixed gap between pulses. Enforces continuity, charge-timeout
//  and abort interlocks. Sits between the board buttons/continuity inputs and the

---
 rtl/fire_sequencer_if.sv | 27 ++
 rtl/fire_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fire_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire_sequencer_if.sv
// Button, continuity, charger and igniter-drive signals of the fire sequencer.
interface fire_sequencer_if #(
    parameter int unsigned NCH = 4
);
    logic           arm_button;
    logic           fire_button;
    logic [NCH-1:0] ch_enable;
    logic [NCH-1:0] cont;
    logic           charge_done;
    logic           charge;
    logic [NCH-1:0] fire;
    logic           arm_led;
    logic           fault;
    logic [2:0]     state;

    // Board side: drives buttons/continuity, observes the drive outputs.
    modport master (
        output arm_button, fire_button, ch_enable, cont, charge_done,
        input  charge, fire, arm_led, fault, state
    );

    // Sequencer side.
    modport slave (
        input  arm_button, fire_button, ch_enable, cont, charge_done,
        output charge, fire, arm_led, fault, state
    );
endinterface

// File: rtl/fire_sequencer.sv
// Multi-channel arm/fire sequencer: debounced buttons, charger gating, ascending-order
// channel pulses with fixed width and gap, continuity/timeout/abort interlocks.
module fire_sequencer #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned TW            = 24,
    parameter int unsigned DEBOUNCE_CYC  = 48000,
    parameter int unsigned CHARGE_TO_CYC = 4800000,
    parameter int unsigned FIRE_CYC      = 480000,
    parameter int unsigned GAP_CYC       = 2400000
) (
    input  logic            clk,
    input  logic            reset_n,
    fire_sequencer_if.slave bus
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCharge = 3'd1;
    localparam logic [2:0] StArmed  = 3'd2;
    localparam logic [2:0] StFire   = 3'd3;
    localparam logic [2:0] StGap    = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;
    localparam logic [2:0] StFault  = 3'd6;

    // Timer values seen in the last cycle of each timed interval.
    localparam logic [TW-1:0] DbLast     = TW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] ChargeLast = TW'(CHARGE_TO_CYC - 1);
    localparam logic [TW-1:0] FireLast   = TW'(FIRE_CYC - 1);
    localparam logic [TW-1:0] GapLast    = TW'(GAP_CYC - 1);

    // Isolates the lowest set bit as a one-hot vector.
    function automatic logic [NCH-1:0] lowest_bit(input logic [NCH-1:0] m);
        return m & (~m + NCH'(1));
    endfunction

    logic           arm_s1_q, arm_s2_q, fire_s1_q, fire_s2_q, cd_s1_q, cd_s2_q;
    logic [NCH-1:0] cont_s1_q, cont_s2_q;

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_s1_q  <= 1'b0;
            arm_s2_q  <= 1'b0;
            fire_s1_q <= 1'b0;
            fire_s2_q <= 1'b0;
            cd_s1_q   <= 1'b0;
            cd_s2_q   <= 1'b0;
            cont_s1_q <= '0;
            cont_s2_q <= '0;
        end else begin
            arm_s1_q  <= bus.arm_button;
            arm_s2_q  <= arm_s1_q;
            fire_s1_q <= bus.fire_button;
            fire_s2_q <= fire_s1_q;
            cd_s1_q   <= bus.charge_done;
            cd_s2_q   <= cd_s1_q;
            cont_s1_q <= bus.cont;
            cont_s2_q <= cont_s1_q;
        end
    end

    // Index 0 is the arm button, index 1 the fire button.
    logic [1:0]          btn_sync, db_q, db_d, rise_q, rise_d;
    logic [1:0][TW-1:0]  db_cnt_q, db_cnt_d;
    logic                arm_db, arm_rise, fire_rise;

    assign btn_sync  = {fire_s2_q, arm_s2_q};
    assign arm_db    = db_q[0];
    assign arm_rise  = rise_q[0];
    assign fire_rise = rise_q[1];

    // Debounce: accept a new level only after it has persisted unbroken for DEBOUNCE_CYC cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]     = db_q[i];
            rise_d[i]   = 1'b0;
            db_cnt_d[i] = '0;
            if (btn_sync[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i]   = btn_sync[i];
                    rise_d[i] = btn_sync[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q     <= '0;
            rise_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            rise_q   <= rise_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic [2:0]     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [NCH-1:0] mask_q, mask_d, cur_q, cur_d, avail, remain;
    logic [NCH-1:0] fire_q, fire_d;
    logic           charge_q, charge_d, arm_led_q, arm_led_d, fault_q, fault_d;

    // Sequencer next state; abort (arm released) is tested first so it beats fire rise and
    // timer expiry. Outputs are registered from the next state so the HV drive is glitch-free.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        avail   = bus.ch_enable & cont_s2_q;
        remain  = mask_q & ~cur_q;
        case (state_q)
            StIdle: begin
                mask_d = '0;
                cur_d  = '0;
                if (arm_rise) state_d = (avail != '0) ? StCharge : StFault;
            end
            StCharge: begin
                if (!arm_db)                    state_d = StIdle;
                else if (cd_s2_q)               state_d = StArmed;
                else if (timer_q == ChargeLast) state_d = StFault;
            end
            StArmed: begin
                if (!arm_db) begin
                    state_d = StIdle;
                end else if (fire_rise) begin
                    // Mask is frozen here; later continuity loss is expected burn-through.
                    mask_d  = avail;
                    cur_d   = lowest_bit(avail);
                    state_d = (avail != '0) ? StFire : StFault;
                end
            end
            StFire: begin
                if (!arm_db) begin
                    state_d = StIdle;
                end else if (timer_q == FireLast) begin
                    mask_d  = remain;
                    cur_d   = '0;
                    state_d = (remain != '0) ? StGap : StDone;
                end
            end
            StGap: begin
                if (!arm_db) begin
                    state_d = StIdle;
                end else if (timer_q == GapLast) begin
                    cur_d   = lowest_bit(mask_q);
                    state_d = StFire;
                end
            end
            StDone, StFault: begin
                if (!arm_db) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Saturating timer, restarted on every state change.
        if (state_d != state_q)  timer_d = '0;
        else if (timer_q == '1)  timer_d = timer_q;
        else                     timer_d = timer_q + 1'b1;

        charge_d  = (state_d == StCharge) || (state_d == StArmed) ||
                    (state_d == StFire) || (state_d == StGap);
        arm_led_d = (state_d == StArmed) || (state_d == StFire) || (state_d == StGap);
        fault_d   = (state_d == StFault);
        fire_d    = (state_d == StFire) ? cur_d : '0;
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            mask_q    <= '0;
            cur_q     <= '0;
            fire_q    <= '0;
            charge_q  <= 1'b0;
            arm_led_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            fire_q    <= fire_d;
            charge_q  <= charge_d;
            arm_led_q <= arm_led_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.fire    = fire_q;
    assign bus.charge  = charge_q;
    assign bus.arm_led = arm_led_q;
    assign bus.fault   = fault_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_fire_sequencer.sv
// Bench for fire_sequencer: scenario table, hand-written corner cases and random stimulus,
// all checked every cycle against a countdown-based behavioural model.
module tb_fire_sequencer;
    localparam int unsigned NCH = 4;
    localparam int unsigned TW  = 8;
    localparam int DB = 4, CTO = 50, FC = 10, GC = 5, NEVER = 255;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fire_sequencer_if #(.NCH(NCH)) bus ();

    fire_sequencer #(
        .NCH(NCH), .TW(TW), .DEBOUNCE_CYC(DB), .CHARGE_TO_CYC(CTO),
        .FIRE_CYC(FC), .GAP_CYC(GC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_st, m_left, m_ch, m_arm_run, m_fire_run;
    logic [NCH-1:0] m_mask, m_cont_p0, m_cont_p1;
    logic           m_arm_p0, m_arm_p1, m_fire_p0, m_fire_p1, m_cd_p0, m_cd_p1;
    logic           m_arm_db, m_fire_db, m_arm_rise, m_fire_rise;

    function automatic int lowest(input logic [NCH-1:0] m);
        for (int i = 0; i < NCH; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_left = 0; m_ch = 0; m_mask = '0;
        m_arm_run = 0; m_fire_run = 0;
        m_arm_p0 = 0; m_arm_p1 = 0; m_fire_p0 = 0; m_fire_p1 = 0; m_cd_p0 = 0; m_cd_p1 = 0;
        m_cont_p0 = '0; m_cont_p1 = '0;
        m_arm_db = 0; m_fire_db = 0; m_arm_rise = 0; m_fire_rise = 0;
    endtask

    task automatic debounce(input logic s, inout logic db, inout int run, output logic rise);
        rise = 1'b0;
        if (s != db) begin
            run++;
            if (run == DB) begin
                db = s; run = 0; rise = s;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] avail;
        avail = bus.ch_enable & m_cont_p1;
        if (m_st >= 1 && m_st <= 4 && !m_arm_db) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (m_arm_rise) begin
                    m_st = (avail != 0) ? 1 : 6;
                    m_left = CTO;
                end
                1: if (m_cd_p1) m_st = 2;
                   else begin
                       m_left--;
                       if (m_left == 0) m_st = 6;
                   end
                2: if (m_fire_rise) begin
                    m_mask = avail;
                    if (avail == 0) m_st = 6;
                    else begin m_ch = lowest(avail); m_st = 3; m_left = FC; end
                end
                3: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mask[m_ch] = 1'b0;
                        if (m_mask != 0) begin m_st = 4; m_left = GC; end
                        else m_st = 5;
                    end
                end
                4: begin
                    m_left--;
                    if (m_left == 0) begin m_ch = lowest(m_mask); m_st = 3; m_left = FC; end
                end
                default: if (!m_arm_db) m_st = 0;
            endcase
        end
        debounce(m_arm_p1, m_arm_db, m_arm_run, m_arm_rise);
        debounce(m_fire_p1, m_fire_db, m_fire_run, m_fire_rise);
        m_arm_p1 = m_arm_p0;   m_arm_p0 = bus.arm_button;
        m_fire_p1 = m_fire_p0; m_fire_p0 = bus.fire_button;
        m_cd_p1 = m_cd_p0;     m_cd_p0 = bus.charge_done;
        m_cont_p1 = m_cont_p0; m_cont_p0 = bus.cont;
    endtask

    function automatic logic [9:0] m_out();
        logic [NCH-1:0] f;
        f = (m_st == 3) ? (NCH'(1) << m_ch) : '0;
        return {3'(m_st), m_st == 6, (m_st >= 2 && m_st <= 4), (m_st >= 1 && m_st <= 4), f};
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.state, bus.fault, bus.arm_led, bus.charge, bus.fire};
    endfunction

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_step();
        @(negedge clk);
        check("cycle", 32'(dut_out()), 32'(m_out()));
    endtask

    task automatic wait_fire(input logic [NCH-1:0] want, input int budget, input string name);
        int n = 0;
        while (bus.fire !== want && n < budget) begin step(); n++; end
        check(name, 32'(bus.fire), 32'(want));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bus.state !== 3'd0 && n < budget) begin step(); n++; end
        check(name, 32'(bus.state), 32'd0);
        repeat (8) step();
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] cont;
        logic [NCH-1:0] cont_f;      // continuity presented from the fire press on
        int             cd_at;       // cycle after arm press when charge_done rises
        int             exp_n;       // number of fire pulses
        logic [15:0]    exp_seq;     // pulse i one-hot at [4i +: 4]
        logic [2:0]     exp_end;
        logic           exp_chg;     // charge ever asserted
        int             exp_chg_cyc; // cycles spent in CHARGE (0: not checked)
    } vec_t;

    vec_t vecs [7];

    task automatic run_case(input int idx, input vec_t v);
        int chg_cyc = 0, npul = 0;
        logic [15:0] seq = '0;
        logic [NCH-1:0] prev = '0;
        logic chg_seen = 1'b0;
        bus.ch_enable = v.en;
        bus.cont = v.cont;
        bus.arm_button = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (c == v.cd_at) bus.charge_done = 1'b1;
            if (c == 70) begin bus.fire_button = 1'b1; bus.cont = v.cont_f; end
            step();
            if (bus.state == 3'd1) chg_cyc++;
            chg_seen |= bus.charge;
            if (bus.fire != '0 && prev == '0) begin
                if (npul < 4) seq[npul*4 +: 4] = bus.fire;
                npul++;
            end
            prev = bus.fire;
        end
        check($sformatf("case%0d_npulses", idx), 32'(npul), 32'(v.exp_n));
        check($sformatf("case%0d_order", idx), 32'(seq), 32'(v.exp_seq));
        check($sformatf("case%0d_end_state", idx), 32'(bus.state), 32'(v.exp_end));
        check($sformatf("case%0d_charge_seen", idx), 32'(chg_seen), 32'(v.exp_chg));
        if (v.exp_chg_cyc != 0)
            check($sformatf("case%0d_charge_cycles", idx), 32'(chg_cyc), 32'(v.exp_chg_cyc));
        bus.arm_button = 1'b0;
        bus.fire_button = 1'b0;
        bus.charge_done = 1'b0;
        wait_idle(30, $sformatf("case%0d_release_idle", idx));
    endtask

    initial begin
        int late, busy;
        vecs[0] = '{4'b1011, 4'b1111, 4'b1111, 28, 3, 16'h0821, 3'd5, 1'b1, 0};
        vecs[1] = '{4'b0100, 4'b0011, 4'b0011, NEVER, 0, 16'h0000, 3'd6, 1'b0, 0};
        vecs[2] = '{4'b1111, 4'b1111, 4'b1111, NEVER, 0, 16'h0000, 3'd6, 1'b1, 50};
        vecs[3] = '{4'b1110, 4'b0110, 4'b0110, 10, 2, 16'h0042, 3'd5, 1'b1, 0};
        vecs[4] = '{4'b1000, 4'b1111, 4'b1111, 0, 1, 16'h0008, 3'd5, 1'b1, 0};
        vecs[5] = '{4'b0011, 4'b0001, 4'b0001, 20, 1, 16'h0001, 3'd5, 1'b1, 0};
        vecs[6] = '{4'b0011, 4'b0011, 4'b0000, 20, 0, 16'h0000, 3'd6, 1'b1, 0};

        bus.arm_button = 1'b0;
        bus.fire_button = 1'b0;
        bus.charge_done = 1'b0;
        bus.ch_enable = '0;
        bus.cont = '0;
        model_reset();
        @(negedge clk);
        check("reset_outputs", 32'(dut_out()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

        // Bouncing arm: 3-cycle presses with 1-cycle drops never debounce.
        bus.ch_enable = 4'b1111;
        bus.cont = 4'b1111;
        busy = 0;
        for (int r = 0; r < 8; r++) begin
            bus.arm_button = 1'b1;
            repeat (3) begin step(); if (bus.state != 3'd0) busy++; end
            bus.arm_button = 1'b0;
            step();
            if (bus.state != 3'd0) busy++;
        end
        check("bounce_never_left_idle", 32'(busy), 32'd0);
        repeat (10) step();

        // Abort three cycles into the second pulse: later channels never fire.
        bus.arm_button = 1'b1;
        repeat (12) step();
        bus.charge_done = 1'b1;
        repeat (5) step();
        bus.fire_button = 1'b1;
        wait_fire(4'b0010, 80, "abort_second_pulse_seen");
        repeat (2) step();
        bus.arm_button = 1'b0;
        bus.fire_button = 1'b0;
        bus.charge_done = 1'b0;
        late = 0;
        repeat (60) begin step(); if ((bus.fire & 4'b1100) != 0) late++; end
        check("abort_no_late_fire", 32'(late), 32'd0);
        check("abort_state_idle", 32'(bus.state), 32'd0);

        // Asynchronous reset in the middle of a pulse.
        bus.ch_enable = 4'b0001;
        bus.cont = 4'b0001;
        bus.arm_button = 1'b1;
        repeat (12) step();
        bus.charge_done = 1'b1;
        repeat (5) step();
        bus.fire_button = 1'b1;
        wait_fire(4'b0001, 40, "reset_pulse_seen");
        repeat (2) step();
        bus.arm_button = 1'b0;
        bus.fire_button = 1'b0;
        bus.charge_done = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset_fire", 32'(bus.fire), 32'd0);
        check("async_reset_charge", 32'(bus.charge), 32'd0);
        check("async_reset_arm_led", 32'(bus.arm_led), 32'd0);
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        check("after_reset_idle", 32'(bus.state), 32'd0);

        // Random stimulus against the model.
        bus.ch_enable = NCH'($urandom);
        bus.cont = NCH'($urandom);
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(59) == 0) bus.arm_button = ~bus.arm_button;
            if ($urandom_range(14) == 0) bus.fire_button = ~bus.fire_button;
            if ($urandom_range(29) == 0) bus.charge_done = ~bus.charge_done;
            if ($urandom_range(19) == 0) bus.cont = NCH'($urandom);
            if ($urandom_range(299) == 0) bus.ch_enable = NCH'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
